// File: rtl/sqrt_loop.sv
// Iterative integer square root: a proportional loop with gain 2^-G that
// drives y toward sqrt(din), taking one SQUARE and one UPDATE cycle per iteration.
module sqrt_loop #(
  parameter int W        = 16,
  parameter int G        = 8,
  parameter int MAX_ITER = 32,
  localparam int OW      = W / 2,
  localparam int CW      = $clog2(MAX_ITER + 1)
) (
  input  logic          clk_100k,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  din,
  output logic [OW-1:0] dout,
  output logic          done,
  output logic          busy,
  output logic          timeout,
  output logic [CW-1:0] iter_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQUARE,
    S_UPDATE
  } state_t;

  localparam logic signed [W+1:0] Y_MAX = {{(W+2-OW){1'b0}}, {OW{1'b1}}};
  localparam logic [CW-1:0]       COUNT_LIMIT = CW'(MAX_ITER);

  state_t r_state;
  state_t w_stateNext;

  logic [W-1:0]  r_dinR;
  logic [W-1:0]  r_sq;
  logic [OW-1:0] r_y;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_dout;
  logic          r_done;
  logic          r_busy;
  logic          r_timeout;
  logic [CW-1:0] r_iterCnt;

  logic [W-1:0]         w_sq;
  logic signed [W:0]    w_err;
  logic signed [W:0]    w_step;
  logic signed [W+1:0]  w_sum;
  logic [OW-1:0]        w_yNext;
  logic                 w_converged;
  logic                 w_terminate;
  logic                 w_accept;

  // OW-bit operand squared fits exactly in W bits.
  assign w_sq   = W'(r_y) * W'(r_y);
  assign w_err  = $signed({1'b0, r_dinR}) - $signed({1'b0, r_sq});
  assign w_step = w_err >>> G;
  assign w_sum  = $signed({{(W+2-OW){1'b0}}, r_y}) + $signed({w_step[W], w_step});

  always_comb begin
    w_yNext = r_y;
    if (w_sum < 0) begin
      w_yNext = '0;
    end else if (w_sum > Y_MAX) begin
      w_yNext = '1;
    end else begin
      w_yNext = w_sum[OW-1:0];
    end
  end

  assign w_converged = !w_err[W] && ((w_step == '0) || (r_y == '1));
  assign w_terminate = w_converged || (r_count == COUNT_LIMIT);
  assign w_accept    = (r_state == S_IDLE) && start;

  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stateNext = S_SQUARE;
        end
      end
      S_SQUARE: begin
        w_stateNext = S_UPDATE;
      end
      S_UPDATE: begin
        w_stateNext = w_terminate ? S_IDLE : S_SQUARE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Datapath and result registers; done is a single-cycle strobe.
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      r_dinR    <= '0;
      r_sq      <= '0;
      r_y       <= '0;
      r_count   <= '0;
      r_dout    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_iterCnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dinR  <= din;
        r_y     <= '0;
        r_count <= '0;
        r_busy  <= 1'b1;
      end
      if (r_state == S_SQUARE) begin
        r_sq    <= w_sq;
        r_count <= r_count + CW'(1);
      end
      if (r_state == S_UPDATE) begin
        r_y <= w_yNext;
        if (w_terminate) begin
          r_dout    <= w_yNext;
          r_iterCnt <= r_count;
          r_timeout <= !w_converged;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
      end
    end
  end

  assign dout     = r_dout;
  assign done     = r_done;
  assign busy     = r_busy;
  assign timeout  = r_timeout;
  assign iter_cnt = r_iterCnt;

endmodule

// File: tb/tb_sqrt_loop.sv
// Scoreboard bench for sqrt_loop: instance A uses MAX_ITER=32, instance B
// uses MAX_ITER=4 so the iteration-limit path can be exercised.
module tb_sqrt_loop;

  logic        clk_100k = 1'b0;
  logic        reset_n  = 1'b0;
  logic        startA   = 1'b0;
  logic        startB   = 1'b0;
  logic [15:0] din      = '0;

  logic [7:0]  doutA, doutB;
  logic        doneA, doneB;
  logic        busyA, busyB;
  logic        timeoutA, timeoutB;
  logic [5:0]  iterA;
  logic [2:0]  iterB;

  typedef struct {
    int inst;
    int dout;
    int iter;
    int tmo;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;

  sqrt_loop #(.W(16), .G(8), .MAX_ITER(32)) dutA (
    .clk_100k (clk_100k),
    .reset_n  (reset_n),
    .start    (startA),
    .din      (din),
    .dout     (doutA),
    .done     (doneA),
    .busy     (busyA),
    .timeout  (timeoutA),
    .iter_cnt (iterA)
  );

  sqrt_loop #(.W(16), .G(8), .MAX_ITER(4)) dutB (
    .clk_100k (clk_100k),
    .reset_n  (reset_n),
    .start    (startB),
    .din      (din),
    .dout     (doutB),
    .done     (doneB),
    .busy     (busyB),
    .timeout  (timeoutB),
    .iter_cnt (iterB)
  );

  always #5 clk_100k = ~clk_100k;

  always @(posedge clk_100k) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s: event seen, none expected", name);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk_100k) begin : monitor
    exp_t e;
    if (doneA || doneB) begin
      if (expQ.size() == 0) begin
        reportFail("unexpected_done");
      end else begin
        e = expQ.pop_front();
        checkOutput("done_instance", doneA ? 0 : 1, e.inst);
        checkOutput("dout", (e.inst == 0) ? int'(doutA) : int'(doutB), e.dout);
        checkOutput("iter_cnt", (e.inst == 0) ? int'(iterA) : int'(iterB), e.iter);
        checkOutput("timeout", (e.inst == 0) ? int'(timeoutA) : int'(timeoutB), e.tmo);
        checkOutput("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic applyStimulus(input int inst, input int dinVal, input int expDout,
                               input int expIter, input int expTmo, input bit doPush);
    exp_t e;
    @(negedge clk_100k);
    din = 16'(dinVal);
    if (inst == 0) startA = 1'b1;
    else           startB = 1'b1;
    if (doPush) begin
      e.inst = inst;
      e.dout = expDout;
      e.iter = expIter;
      e.tmo  = expTmo;
      e.cyc  = cyc + 1 + 2 * expIter;
      expQ.push_back(e);
    end
    @(negedge clk_100k);
    startA = 1'b0;
    startB = 1'b0;
    checkOutput("busy_after_accept", (inst == 0) ? int'(busyA) : int'(busyB), 1);
  endtask

  task automatic waitResult();
    int n = 0;
    while (expQ.size() > 0 && n < 200) begin
      @(negedge clk_100k);
      n++;
    end
    if (expQ.size() > 0) begin
      checkCount++;
      $display("[TB] FAIL result_wait: got %0d pending results, expected 0", expQ.size());
      expQ.delete();
    end
    @(negedge clk_100k);
    checkOutput("done_one_cycle", int'(doneA | doneB), 0);
    checkOutput("busy_cleared", int'(busyA | busyB), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk_100k);
    checkOutput("reset_dout", int'(doutA), 0);
    checkOutput("reset_done", int'(doneA), 0);
    checkOutput("reset_busy", int'(busyA), 0);
    checkOutput("reset_timeout", int'(timeoutA), 0);
    checkOutput("reset_iter_cnt", int'(iterA), 0);
    reset_n = 1'b1;
    @(negedge clk_100k);

    applyStimulus(0, 0, 0, 1, 0, 1'b1);
    waitResult();
    applyStimulus(0, 10000, 99, 6, 0, 1'b1);
    waitResult();
    applyStimulus(0, 65535, 255, 2, 0, 1'b1);
    waitResult();
    applyStimulus(1, 10000, 97, 4, 1, 1'b1);
    waitResult();

    // Restart attempt mid-run must be ignored.
    applyStimulus(0, 10000, 99, 6, 0, 1'b1);
    repeat (3) @(negedge clk_100k);
    din    = 16'd0;
    startA = 1'b1;
    @(negedge clk_100k);
    startA = 1'b0;
    waitResult();
    repeat (4) @(negedge clk_100k);
    checkOutput("dout_held", int'(doutA), 99);
    checkOutput("iter_cnt_held", int'(iterA), 6);

    // Asynchronous reset at edge 5 aborts the run without a done pulse.
    applyStimulus(0, 10000, 0, 0, 0, 1'b0);
    repeat (5) @(posedge clk_100k);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_dout", int'(doutA), 0);
    checkOutput("abort_done", int'(doneA), 0);
    checkOutput("abort_busy", int'(busyA), 0);
    checkOutput("abort_timeout", int'(timeoutA | timeoutB), 0);
    checkOutput("abort_iter_cnt", int'(iterA), 0);
    repeat (3) @(negedge clk_100k);
    reset_n = 1'b1;
    repeat (12) @(negedge clk_100k);
    applyStimulus(0, 0, 0, 1, 0, 1'b1);
    waitResult();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
